instr_mem_bridge: RTL and testbench

- Sits directly upstream of the fetch stage, between its instruction port (req/gnt/addr/rdata/rvalid/err) and the instruction memory bus.
- Forwards word-aligned fetch requests to a pipelined, variable-latency memory bus, and bounds outstanding transactions by credit.
- Buffers responses in a small FIFO so fetch can stall without losing data.
- Discards responses to requests issued before a flush (branch/trap redirect).

---
 rtl/instr_mem_bridge.sv | 121 ++++++++++++
 tb/tb_instr_mem_bridge.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_bridge.sv
// Bridge between the fetch-stage instruction port and a pipelined, variable-latency memory bus.
// Credit-limited issue, response FIFO, and post-flush discard of stale in-flight responses.
module instr_mem_bridge #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        instr_rready_i,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,
  output logic        protocol_err_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             perr_q, perr_d;
  logic [32:0]      mem_q [DEPTH];

  logic [CNT_W:0] occupancy;
  logic           credit_ok;
  logic           rsp_accept;
  logic           rsp_unsol;
  logic           push;
  logic           pop;
  logic           head_valid;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Buffered responses count against credit so a push can never find the FIFO full.
  assign occupancy   = {1'b0, inflight_q} + {1'b0, count_q};
  assign credit_ok   = occupancy < (CNT_W + 1)'(DEPTH);
  assign bus_req_o   = instr_req_i & credit_ok & ~flush_i;
  assign bus_addr_o  = {instr_addr_i[31:2], 2'b00};
  assign instr_gnt_o = bus_req_o & bus_gnt_i;

  assign rsp_accept = bus_rvalid_i & (inflight_q != '0);
  assign rsp_unsol  = bus_rvalid_i & (inflight_q == '0);
  assign push       = rsp_accept & (discard_q == '0) & ~flush_i;

  assign head_valid     = (count_q != '0);
  assign instr_rvalid_o = head_valid & ~flush_i;
  assign pop            = instr_rvalid_o & instr_rready_i;
  // Head is masked when empty so stale storage never leaks onto the port.
  assign instr_rdata_o  = head_valid ? mem_q[rd_ptr_q][31:0] : '0;
  assign instr_err_o    = head_valid ? mem_q[rd_ptr_q][32] : 1'b0;
  assign protocol_err_o = perr_q;

  always_comb begin
    inflight_d = inflight_q + CNT_W'(instr_gnt_o) - CNT_W'(rsp_accept);
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    perr_d     = perr_q | rsp_unsol;

    if (flush_i) begin
      // Everything still outstanding after this cycle belongs to the old stream.
      count_d   = '0;
      rd_ptr_d  = wr_ptr_q;
      discard_d = inflight_q - CNT_W'(rsp_accept);
    end else begin
      if (rsp_accept && (discard_q != '0)) begin
        discard_d = discard_q - CNT_W'(1);
      end
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      perr_q     <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      perr_q     <= perr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus_err_i, bus_rdata_i};
    end
  end

endmodule

// File: tb/tb_instr_mem_bridge.sv
// Cycle-vector bench for instr_mem_bridge (DEPTH=2): per-cycle expected request-path outputs
// from a table, response data checked through a scoreboard queue of expected {err, data}.
module tb_instr_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        instr_rready_i;
  logic        flush_i;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;
  logic        protocol_err_o;

  always #5 clk = ~clk;

  instr_mem_bridge #(.DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_req_i   (instr_req_i),
    .instr_addr_i  (instr_addr_i),
    .instr_gnt_o   (instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o (instr_rdata_o),
    .instr_err_o   (instr_err_o),
    .instr_rready_i(instr_rready_i),
    .flush_i       (flush_i),
    .bus_req_o     (bus_req_o),
    .bus_addr_o    (bus_addr_o),
    .bus_gnt_i     (bus_gnt_i),
    .bus_rvalid_i  (bus_rvalid_i),
    .bus_rdata_i   (bus_rdata_i),
    .bus_err_i     (bus_err_i),
    .protocol_err_o(protocol_err_o)
  );

  typedef struct packed {
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        bv;
    logic [31:0] bd;
    logic        be;
    logic        rr;
    logic        fl;
    logic        push;    // response is expected to reach the fetch port
    logic        e_breq;
    logic [31:0] e_baddr;
    logic        e_gnt;
    logic        e_rv;
    logic        e_perr;
  } vec_t;

  vec_t        vecs[$];
  logic [32:0] sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          prev_rst = 1'b0;

  function automatic vec_t mk(input logic r, input logic rq, input logic [31:0] a,
                              input logic g, input logic bv, input logic [31:0] bd,
                              input logic be, input logic rr, input logic fl, input logic pu,
                              input logic ebr, input logic eg, input logic erv,
                              input logic ep);
    vec_t v;
    v.rst = r; v.req = rq; v.addr = a; v.gnt = g; v.bv = bv; v.bd = bd; v.be = be;
    v.rr = rr; v.fl = fl; v.push = pu;
    v.e_breq = ebr; v.e_baddr = {a[31:2], 2'b00}; v.e_gnt = eg; v.e_rv = erv; v.e_perr = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v, input bit do_chk);
    rst = v.rst; instr_req_i = v.req; instr_addr_i = v.addr; bus_gnt_i = v.gnt;
    bus_rvalid_i = v.bv; bus_rdata_i = v.bd; bus_err_i = v.be;
    instr_rready_i = v.rr; flush_i = v.fl;
    #2;
    if (do_chk) begin
      check("bus_req", 32'(bus_req_o), 32'(v.e_breq));
      check("bus_addr", bus_addr_o, v.e_baddr);
      check("instr_gnt", 32'(instr_gnt_o), 32'(v.e_gnt));
      check("instr_rvalid", 32'(instr_rvalid_o), 32'(v.e_rv));
      check("protocol_err", 32'(protocol_err_o), 32'(v.e_perr));
      if (prev_rst) begin
        check("post_reset_rdata", instr_rdata_o, 32'h0);
        check("post_reset_err", 32'(instr_err_o), 32'h0);
      end
      if (instr_rvalid_o) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got rvalid with data 0x%08h, expected no response",
                   instr_rdata_o);
        end else begin
          check("sb_rdata", instr_rdata_o, sb_q[0][31:0]);
          check("sb_err", 32'(instr_err_o), 32'(sb_q[0][32]));
          if (instr_rready_i) void'(sb_q.pop_front());
        end
      end
    end
    if (v.bv && v.push) sb_q.push_back({v.be, v.bd});
    @(posedge clk);
    #1;
    if (v.rst) sb_q.delete();
    prev_rst = v.rst;
  endtask

  initial begin
    logic [31:0] rnd;
    //           rst req addr          gnt bv bdata          be rr fl pu  breq gnt rv perr
    // reset and single fetch
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0000_1006, 1, 0, 32'h0,       0, 0, 0, 0,  1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 0, 0));
    // backpressure: credit exhausted by buffered responses
    vecs.push_back(mk(0, 1, 32'h10,       1, 0, 32'h0,        0, 0, 0, 0,  1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h14,       1, 0, 32'h0,        0, 0, 0, 0,  1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h18,       1, 1, 32'h11,       0, 0, 0, 1,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h18,       1, 1, 32'h22,       0, 0, 0, 1,  0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 32'h18,       1, 0, 32'h0,        0, 0, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 32'h18,       0, 0, 32'h0,        0, 1, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 32'h18,       1, 0, 32'h0,        0, 0, 0, 0,  1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h33,       0, 1, 0, 1,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 0, 0));
    // flush with two in flight, then a fresh fetch
    vecs.push_back(mk(0, 1, 32'h100,      1, 0, 32'h0,        0, 0, 0, 0,  1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h104,      1, 0, 32'h0,        0, 0, 0, 0,  1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h108,      1, 0, 32'h0,        0, 0, 1, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h200,      1, 1, 32'hBAD0,     0, 1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h200,      1, 1, 32'hBAD1,     0, 1, 0, 0,  1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hC0DE_0200, 0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 0,  0, 0, 1, 0));
    // flush coinciding with a response: one left to discard
    vecs.push_back(mk(0, 1, 32'h300,      1, 0, 32'h0,        0, 0, 0, 0,  1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h304,      1, 0, 32'h0,        0, 0, 0, 0,  1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hBAD2,     0, 1, 1, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hBAD3,     0, 1, 0, 0,  0, 0, 0, 0));
    // two grants accepted proves in-flight drained to zero
    vecs.push_back(mk(0, 1, 32'h400,      1, 0, 32'h0,        0, 0, 0, 0,  1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h404,      1, 0, 32'h0,        0, 0, 0, 0,  1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h408,      1, 0, 32'h0,        0, 0, 0, 0,  0, 0, 0, 0));
    // bus error travels with its data
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h55,       1, 0, 0, 1,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h66,       0, 1, 0, 1,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 0,  0, 0, 1, 0));
    // unsolicited response sets sticky protocol error
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h77,       0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 0, 1));
    // reset with one in flight and one buffered
    vecs.push_back(mk(0, 1, 32'h500,      1, 0, 32'h0,        0, 0, 0, 0,  1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 32'h504,      1, 0, 32'h0,        0, 0, 0, 0,  1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h88,       0, 0, 0, 1,  0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h99,       0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 32'h600,      1, 0, 32'h0,        0, 0, 0, 0,  1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 32'h604,      1, 0, 32'h0,        0, 0, 0, 0,  1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hA1,       0, 0, 0, 1,  0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hA2,       0, 1, 0, 1,  0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 0,  0, 0, 1, 1));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i != 0);
    end

    // Back-to-back single fetches with random data walk both pointers through several wraps.
    for (int k = 0; k < 5; k++) begin
      rnd = $urandom;
      apply(mk(0, 1, 32'h700 + 32'(k * 4), 1, 0, 32'h0, 0, 0, 0, 0, 1, 1, 0, 1), 1'b1);
      apply(mk(0, 0, 32'h0, 0, 1, rnd, rnd[0], 0, 0, 1, 0, 0, 0, 1), 1'b1);
      apply(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 1, 1), 1'b1);
    end

    // Reset clears the sticky error.
    apply(mk(1, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1);
    apply(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);

    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
